// File: rtl/pipelined_rca_addsub.sv
// ============================================================================
// Module      : pipelined_rca_addsub
// Description : Pipelined ripple-carry adder/subtractor, one SEG-bit segment
//               per stage, valid/ready on both sides, carry-out and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_rca_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  logic             w_stall;

  // Per-stage combinational view: what each stage sees and produces.
  logic             w_vin    [STAGES];
  logic             w_cin    [STAGES];
  logic [WIDTH-1:0] w_ain    [STAGES];
  logic [WIDTH-1:0] w_bin    [STAGES];
  logic [WIDTH-1:0] w_sumin  [STAGES];
  logic [WIDTH-1:0] w_sumout [STAGES];
  logic [SEG:0]     w_seg    [STAGES];
  logic             w_ovf    [STAGES];

  // Per-stage registers: valid, carry, overflow, skewed operands, partial sum.
  logic             r_vld [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        // Subtraction folds into addition: a + ~b + ~cin == a - b - cin.
        assign w_vin[k]   = in_valid;
        assign w_cin[k]   = sub ? ~cin : cin;
        assign w_ain[k]   = a;
        assign w_bin[k]   = sub ? ~b : b;
        assign w_sumin[k] = '0;
      end else begin : g_body
        assign w_vin[k]   = r_vld[k-1];
        assign w_cin[k]   = r_c[k-1];
        assign w_ain[k]   = r_a[k-1];
        assign w_bin[k]   = r_b[k-1];
        assign w_sumin[k] = r_sum[k-1];
      end

      assign w_seg[k] = {1'b0, w_ain[k][k*SEG +: SEG]}
                      + {1'b0, w_bin[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, w_cin[k]};

      assign w_sumout[k] = (w_sumin[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG)))
                         | (WIDTH'(w_seg[k][SEG-1:0]) << (k*SEG));

      // Sign overflow of this segment's top bit; only the last stage's is used.
      assign w_ovf[k] = (w_ain[k][(k+1)*SEG-1] == w_bin[k][(k+1)*SEG-1])
                     && (w_seg[k][SEG-1] != w_ain[k][(k+1)*SEG-1]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_ovf[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vin[k];
        r_c[k]   <= w_seg[k][SEG];
        r_ovf[k] <= w_ovf[k];
        r_a[k]   <= w_ain[k];
        r_b[k]   <= w_bin[k];
        r_sum[k] <= w_sumout[k];
      end
    end
  end

  // The whole pipeline freezes while a finished result waits downstream.
  assign w_stall   = r_vld[STAGES-1] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_rca_addsub.sv
// ============================================================================
// Module      : tb_pipelined_rca_addsub
// Description : Scoreboard bench for pipelined_rca_addsub (WIDTH=16, STAGES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_rca_addsub;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          cyc;
    int          st;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          stalls = 0;
  bit          hold_seen = 0;
  bit          ready_must_be_1 = 0;
  logic [15:0] h_sum;
  logic        h_cout;
  logic        h_ovf;

  pipelined_rca_addsub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical operation.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    exp_t r;
    int ua, ub, sa, sb, u, s;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!ms) begin
      u   = ua + ub + int'(mc);
      s   = sa + sb + int'(mc);
      r.c = (u > 65535);
    end else begin
      u   = ua - ub - int'(mc);
      s   = sa - sb - int'(mc);
      r.c = (u >= 0);
    end
    r.s   = u[15:0];
    r.o   = (s > 32767) || (s < -32768);
    r.cyc = 0;
    r.st  = 0;
    return r;
  endfunction

  // Drive one beat, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                      input logic tsub, input bit use_exp, input logic [15:0] es,
                      input logic ec, input logic eo);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    cin      = tcin;
    sub      = tsub;
    n        = 0;
    @(negedge clk);
    if (ready_must_be_1) chk("stream_in_ready", 32'(in_ready), 1);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual in_ready=0 required=1 within 100 cycles");
    end else begin
      if (use_exp) begin
        e.s = es;
        e.c = ec;
        e.o = eo;
      end else begin
        e = model(ta, tb, tcin, tsub);
      end
      e.cyc = cyc;
      e.st  = stalls;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    cin      = 1'($urandom);
    sub      = 1'($urandom);
  endtask

  task automatic send_rand();
    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual pending=%0d required=0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: output checks, hold stability and scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_seen = 0;
      end else begin
        if (hold_seen) begin
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_sum", 32'(sum), 32'(h_sum));
          chk("hold_cout", 32'(cout), 32'(h_cout));
          chk("hold_ovf", 32'(ovf), 32'(h_ovf));
        end
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", 32'(in_ready), 0);
          stalls++;
          hold_seen = 1;
          h_sum     = sum;
          h_cout    = cout;
          h_ovf     = ovf;
        end else begin
          hold_seen = 0;
          chk("in_ready", 32'(in_ready), 1);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: actual sum=0x%0h required=no output", sum);
          end else begin
            m_e = q.pop_front();
            chk("sum", 32'(sum), 32'(m_e.s));
            chk("cout", 32'(cout), 32'(m_e.c));
            chk("ovf", 32'(ovf), 32'(m_e.o));
            chk("latency", cyc - m_e.cyc, STAGES + stalls - m_e.st);
          end
        end
      end
    end
  end

  initial begin
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed beats with known answers.
    send(16'h0002, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0); drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0); drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1); drain();
    send(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0); drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1); drain();
    send(16'h0010, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h000B, 1'b1, 1'b0); drain();
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0); drain();
    send(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1); drain();

    // Back-to-back random stream.
    ready_must_be_1 = 1;
    repeat (100) send_rand();
    ready_must_be_1 = 0;
    drain();

    // Backpressure mid-stream.
    fork
      begin
        repeat (8) send_rand();
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight.
    repeat (3) send_rand();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(out_valid), 1);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_sum", 32'(sum), 0);
    chk("async_rst_cout", 32'(cout), 0);
    chk("async_rst_ovf", 32'(ovf), 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_rca_addsub.md
Name: pipelined_rca_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides.
- The WIDTH-bit operation is split into STAGES equal segments, one per pipeline stage. Carry is registered between segments.
- Sustains one operation per clock and provides carry-out and signed-overflow flags.
- Sits in the arithmetic datapath as the clocked, wide successor of the team's 4-bit gate-level ripple adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage adds WIDTH/STAGES bits (SEG). Legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  add: carry-out; sub: 1 = no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = !stall (combinational from out_ready). When stall=1, every pipeline register holds, including valid bits, data and carries.
- Subtract mapping:
  - B' = sub ? ~b : b
  - carry-in c0 = sub ? ~cin : cin
  - Hence sub=1 computes a + ~b + ~cin = a - b - cin.
- Stage k (k = 0..STAGES-1):
  - Adds bits [k*SEG +: SEG] of A and B' plus the registered carry from stage k-1 (stage 0 uses c0).
  - Registers its segment sum, its carry-out, a valid bit, and the not-yet-consumed upper operand bits. Operands are skewed, so lower result segments travel with the beat.
- Latency:
  - A beat accepted at edge n appears on out_valid/sum after edge n+STAGES-1. Registered output: first visible cycle is STAGES cycles after acceptance, measured from the accepting edge.
  - STAGES=1 gives a single registered adder.
- Throughput: one beat per cycle when out_ready=1. Results leave in acceptance order; no reordering or dropping.
- Flags, taken with the last segment of the same beat:
  - cout = final carry-out.
  - ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]). For sub this is the standard signed-subtract overflow.
- Bubbles: in_valid=0 inserts an invalid slot that advances unless stalled. Data registers of invalid slots may update; out_valid must stay 0 for them.
- sum/cout/ovf are stable while out_valid=1 and out_ready=0.
- Reset (asynchronous assert, synchronous deassert by the environment): all valid bits, sum, cout and ovf clear to 0 immediately.
  - in_ready reads 1 during and after reset (out_valid=0).
  - In-flight beats are discarded on reset mid-operation; no partial result is emitted.
- Simultaneous accept and deliver in one cycle is legal and required for full throughput.
- X on a/b/cin/sub while in_valid=0 must not propagate to out_valid.

Test Plan (WIDTH=16, STAGES=4, out_ready=1 unless stated):
- Reset then a=0x0002, b=0x0002, cin=1, sub=0, one beat → after 4 cycles out_valid=1 for one cycle, sum=0x0005, cout=0, ovf=0.
- Carry ripple across all segments: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0003, b=0x0005, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0004, cin=1, sub=1 → sum=0x000B, cout=1.
- Streaming: 100 random back-to-back beats with in_valid held 1 → 100 results in order, one per cycle, matching the reference model a±b±cin modulo 2^16 with flags; in_ready constantly 1.
- Backpressure: stream 8 beats, drop out_ready for 5 cycles mid-stream → in_ready=0 and outputs frozen during the hold. No beat lost or duplicated; full sequence resumes in order.
- Reset mid-operation: accept 3 beats, assert rst_n=0 two cycles later → out_valid/sum/cout/ovf go 0 without waiting for a clock edge. After release, none of the 3 beats appear; a new beat 0x1234+0x1111 yields 0x2345 after 4 cycles.
